mpy_rr_sched: RTL and testbench

- Round-robin scheduler that shares one sequential shift-add unsigned multiplier between two requesters.
- Each requester presents operands with a req/gnt handshake and later receives a one-cycle result-valid pulse with its product.
- Sits between client logic (e.g. two datapath lanes) and the multiplier datapath. It replaces free-running multipliers, which have no start or done signal, with a sequenced start/run/done flow.

---
 rtl/mpy_rr_sched_pkg.sv | 16 +
 rtl/mpy_seq_core.sv | 75 +++++++
 rtl/mpy_rr_sched.sv | 113 +++++++++++
 tb/tb_mpy_rr_sched.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mpy_rr_sched_pkg.sv
// Shared definitions for the round-robin multiplier scheduler:
// state encoding, default operand width and the step-counter width helper.
package mpy_rr_sched_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    function automatic int clog2(input int value);
        return $clog2(value);
    endfunction

endpackage

// File: rtl/mpy_seq_core.sv
// Sequential shift-add unsigned multiplier: one step per cycle, WIDTH steps.
// done and product are presented combinationally during the final step.
module mpy_seq_core
    import mpy_rr_sched_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int                CNT_W     = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic                 active_q, active_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]       upper_sum;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        active_d  = active_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        done      = 1'b0;
        upper_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + {1'b0, (mplier_q[0] ? mcand_q : '0)};
        // Carry out of the upper-half add lands in the MSB after the shift.
        product   = {upper_sum, acc_q[WIDTH-1:1]};

        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
        end else if (active_q) begin
            acc_d    = product;
            mplier_d = mplier_q >> 1;
            if (cnt_q == LAST_STEP) begin
                done     = 1'b1;
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments; reset is synchronous, sampled at the edge.
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/mpy_rr_sched.sv
// Round-robin scheduler sharing one sequential multiplier between two requesters.
// Registered gnt/vld pulses; each requester's product is held until its next vld.
module mpy_rr_sched
    import mpy_rr_sched_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    output logic                 gnt0,
    output logic                 vld0,
    output logic [2*WIDTH-1:0]   prod0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 gnt1,
    output logic                 vld1,
    output logic [2*WIDTH-1:0]   prod1,
    output logic                 busy
);

    state_e               state_q, state_d;
    logic                 last_q, last_d;
    logic                 gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                 vld0_q, vld0_d, vld1_q, vld1_d;
    logic [2*WIDTH-1:0]   prod0_q, prod0_d, prod1_q, prod1_d;

    logic                 win;
    logic                 core_start;
    logic [WIDTH-1:0]     core_a, core_b;
    logic                 core_done;
    logic [2*WIDTH-1:0]   core_product;

    mpy_seq_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst     (rst),
        .start   (core_start),
        .a       (core_a),
        .b       (core_b),
        .done    (core_done),
        .product (core_product)
    );

    // On a tie the requester not served last wins; otherwise the lone requester.
    assign win    = (req0 && req1) ? ~last_q : req1;
    assign core_a = win ? a1 : a0;
    assign core_b = win ? b1 : b0;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        vld0_d     = 1'b0;
        vld1_d     = 1'b0;
        prod0_d    = prod0_q;
        prod1_d    = prod1_q;
        core_start = 1'b0;

        if (state_q == S_IDLE) begin
            if (req0 || req1) begin
                core_start = 1'b1;
                gnt0_d     = ~win;
                gnt1_d     = win;
                last_d     = win;
                state_d    = S_RUN;
            end
        end else if (core_done) begin
            if (last_q) begin
                prod1_d = core_product;
                vld1_d  = 1'b1;
            end else begin
                prod0_d = core_product;
                vld0_d  = 1'b1;
            end
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            vld0_q  <= 1'b0;
            vld1_q  <= 1'b0;
            prod0_q <= '0;
            prod1_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            vld0_q  <= vld0_d;
            vld1_q  <= vld1_d;
            prod0_q <= prod0_d;
            prod1_q <= prod1_d;
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign vld0  = vld0_q;
    assign vld1  = vld1_q;
    assign prod0 = prod0_q;
    assign prod1 = prod1_q;
    assign busy  = (state_q == S_RUN);

endmodule

// File: tb/tb_mpy_rr_sched.sv
// Self-checking bench for mpy_rr_sched: directed steps plus random traffic,
// compared every cycle against a timeline-level reference model.
module tb_mpy_rr_sched;

    localparam int W  = 4;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic          gnt0, gnt1, vld0, vld1, busy;
    logic [PW-1:0] prod0, prod1;

    mpy_rr_sched #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .a0    (a0),
        .b0    (b0),
        .gnt0  (gnt0),
        .vld0  (vld0),
        .prod0 (prod0),
        .req1  (req1),
        .a1    (a1),
        .b1    (b1),
        .gnt1  (gnt1),
        .vld1  (vld1),
        .prod1 (prod1),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a cycle timeline, not a state machine.
    int            m_left = 0;
    bit            m_last = 1'b1;
    bit            m_srv  = 1'b0;
    logic [PW-1:0] m_prod = '0;
    logic [1:0]    e_gnt = '0, e_vld = '0;
    logic          e_busy = 1'b0;
    logic [PW-1:0] e_prod0 = '0, e_prod1 = '0;

    logic          prev_busy = 1'b0;
    bit            rec = 1'b0;
    int            order[$];
    int            low_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit w;
        if (rst) begin
            m_left  = 0;
            m_last  = 1'b1;
            e_gnt   = '0;
            e_vld   = '0;
            e_busy  = 1'b0;
            e_prod0 = '0;
            e_prod1 = '0;
        end else begin
            e_gnt = '0;
            e_vld = '0;
            if (m_left == 0) begin
                if (req0 || req1) begin
                    w        = (req0 && req1) ? !m_last : req1;
                    m_prod   = w ? PW'(a1) * PW'(b1) : PW'(a0) * PW'(b0);
                    m_srv    = w;
                    m_last   = w;
                    m_left   = W;
                    e_gnt[w] = 1'b1;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    e_vld[m_srv] = 1'b1;
                    if (m_srv) e_prod1 = m_prod;
                    else       e_prod0 = m_prod;
                end
            end
            e_busy = (m_left != 0);
        end
    endtask

    task automatic step();
        prev_busy = busy;
        @(posedge clk);
        model_edge();
        #1;
        check("gnt0", gnt0, e_gnt[0]);
        check("gnt1", gnt1, e_gnt[1]);
        check("vld0", vld0, e_vld[0]);
        check("vld1", vld1, e_vld[1]);
        check("busy", busy, e_busy);
        check("prod0", prod0, e_prod0);
        check("prod1", prod1, e_prod1);
        if (gnt0 === 1'b1 || gnt1 === 1'b1)
            check("gnt_after_busy", prev_busy, 0);
        if (rec) begin
            if (gnt0 === 1'b1) order.push_back(0);
            if (gnt1 === 1'b1) order.push_back(1);
            if (busy === 1'b0) low_cnt++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic op(input bit k, input int a, input int b, input int exp_prod);
        if (k) begin req1 = 1'b1; a1 = W'(a); b1 = W'(b); end
        else   begin req0 = 1'b1; a0 = W'(a); b0 = W'(b); end
        step();
        check(k ? "op_gnt1" : "op_gnt0", k ? gnt1 : gnt0, 1);
        req0 = 1'b0;
        req1 = 1'b0;
        run(W);
        check(k ? "op_vld1_latency" : "op_vld0_latency", k ? vld1 : vld0, 1);
        check(k ? "op_prod1" : "op_prod0", k ? prod1 : prod0, exp_prod);
    endtask

    initial begin
        bit            pend0, pend1;
        int            grants;
        logic [PW-1:0] keep1;

        // Reset, then abort an operation mid-run with a 2-cycle reset.
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        req0 = 1'b1; a0 = 4'd9; b0 = 4'd7;
        step();
        req0 = 1'b0;
        run(2);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_prod0", prod0, 0);
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        run(W + 1);
        check("rst_no_vld0", vld0, 0);

        // Single op on requester 0; prod1 must not move.
        keep1 = e_prod1;
        op(0, 13, 11, 143);
        check("single_prod1_held", prod1, keep1);

        // Corners through requester 1.
        op(1, 15, 15, 225);
        op(1, 0, 12, 0);
        op(1, 1, 15, 15);
        op(1, 8, 2, 16);

        // Tie right after reset: requester 0 wins first.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0 = 1'b1; a0 = 4'd3; b0 = 4'd5;
        req1 = 1'b1; a1 = 4'd6; b1 = 4'd7;
        step();
        check("tie_gnt0_first", gnt0, 1);
        check("tie_gnt1_waits", gnt1, 0);
        req0 = 1'b0;
        run(W);
        check("tie_vld0", vld0, 1);
        check("tie_prod0", prod0, 15);
        step();
        check("tie_gnt1_on_vld_edge", gnt1, 1);
        req1 = 1'b0;
        run(W);
        check("tie_vld1", vld1, 1);
        check("tie_prod1", prod1, 42);

        // Fairness: both requests held for six operations.
        order.delete();
        low_cnt = 0;
        rec = 1'b1;
        req0 = 1'b1; a0 = 4'd5; b0 = 4'd9;
        req1 = 1'b1; a1 = 4'd14; b1 = 4'd3;
        run(6 * (W + 1));
        rec = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        run(W + 1);
        check("fair_grant_count", order.size(), 6);
        for (int i = 0; i < order.size(); i++)
            check("fair_order", order[i], i % 2);
        check("fair_busy_low_cycles", low_cnt, 6);

        // Random traffic with the req/gnt handshake honoured.
        pend0  = 1'b0;
        pend1  = 1'b0;
        grants = 0;
        for (int cyc = 0; cyc < 6000 && grants < 200; cyc++) begin
            if (!pend0 && $urandom_range(0, 2) != 0) begin
                pend0 = 1'b1;
                a0 = W'($urandom_range(0, (1 << W) - 1));
                b0 = W'($urandom_range(0, (1 << W) - 1));
            end
            if (!pend1 && $urandom_range(0, 2) != 0) begin
                pend1 = 1'b1;
                a1 = W'($urandom_range(0, (1 << W) - 1));
                b1 = W'($urandom_range(0, (1 << W) - 1));
            end
            req0 = pend0;
            req1 = pend1;
            step();
            if (e_gnt[0]) begin pend0 = 1'b0; req0 = 1'b0; grants++; end
            if (e_gnt[1]) begin pend1 = 1'b0; req1 = 1'b0; grants++; end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("rand_ops_granted", (grants >= 200) ? 1 : 0, 1);
        run(W + 1);
        check("rand_final_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
